// File: rtl/req_latch_arbiter.sv
// Latching fixed-priority arbiter: captures a request vector, then issues one-hot grants
// one at a time in priority order until the latched vector is drained.
// Optional gnt_idx output is enabled by defining REQ_LATCH_ARBITER_GNT_IDX_EN.
module req_latch_arbiter #(
  parameter int PRIO_MSB = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req,
  output logic       gnt_valid,
  input  logic       gnt_ready,
  output logic [7:0] gnt,
  output logic       busy
`ifdef REQ_LATCH_ARBITER_GNT_IDX_EN
  ,
  output logic [2:0] gnt_idx
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_GRANT} state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_pending;
  logic [7:0] r_gnt;
  logic       r_gnt_valid;
  logic [7:0] w_pick;
  logic [7:0] w_remain;

  // Highest-priority set bit; later loop iterations override earlier ones.
  function automatic logic [7:0] f_pick(input logic [7:0] v);
    logic [7:0] onehot;
    onehot = '0;
    if (PRIO_MSB != 0) begin
      for (int i = 0; i < 8; i++) if (v[i]) begin onehot = '0; onehot[i] = 1'b1; end
    end else begin
      for (int i = 7; i >= 0; i--) if (v[i]) begin onehot = '0; onehot[i] = 1'b1; end
    end
    return onehot;
  endfunction

  assign w_pick   = f_pick(r_pending);
  assign w_remain = r_pending & ~r_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (req_valid && (req != 8'h00)) w_state_nxt = S_ARB;
      S_ARB:   w_state_nxt = S_GRANT;
      S_GRANT: if (gnt_ready) w_state_nxt = (w_remain != 8'h00) ? S_ARB : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (r_state == S_IDLE);
    busy      = (r_state != S_IDLE);
    gnt       = r_gnt;
    gnt_valid = r_gnt_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending   <= '0;
      r_gnt       <= '0;
      r_gnt_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (req_valid) r_pending <= req;
        S_ARB: begin
          r_gnt       <= w_pick;
          r_gnt_valid <= 1'b1;
        end
        S_GRANT: if (gnt_ready) begin
          r_pending   <= w_remain;
          r_gnt       <= '0;
          r_gnt_valid <= 1'b0;
        end
        default: begin
          r_pending   <= '0;
          r_gnt       <= '0;
          r_gnt_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef REQ_LATCH_ARBITER_GNT_IDX_EN
  logic [2:0] r_gnt_idx;
  logic [2:0] w_pick_idx;

  always_comb begin
    w_pick_idx = '0;
    for (int i = 0; i < 8; i++) if (w_pick[i]) w_pick_idx = 3'(i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              r_gnt_idx <= '0;
    else if (r_state == S_ARB)               r_gnt_idx <= w_pick_idx;
    else if (r_state != S_GRANT || gnt_ready) r_gnt_idx <= '0;
  end

  assign gnt_idx = r_gnt_idx;
`endif

endmodule

// File: tb/tb_req_latch_arbiter.sv
// Directed testbench for req_latch_arbiter: MSB-priority instance (u_msb) and
// LSB-priority instance (u_lsb) share clock and reset.
module tb_req_latch_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid1, req_ready1, gnt_valid1, gnt_ready1, busy1;
  logic [7:0] req1, gnt1;
  logic       req_valid0, req_ready0, gnt_valid0, gnt_ready0, busy0;
  logic [7:0] req0, gnt0;
`ifdef REQ_LATCH_ARBITER_GNT_IDX_EN
  logic [2:0] gnt_idx1, gnt_idx0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  req_latch_arbiter #(.PRIO_MSB(1)) u_msb (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(req_ready1), .req(req1),
    .gnt_valid(gnt_valid1), .gnt_ready(gnt_ready1), .gnt(gnt1), .busy(busy1)
`ifdef REQ_LATCH_ARBITER_GNT_IDX_EN
    , .gnt_idx(gnt_idx1)
`endif
  );

  req_latch_arbiter #(.PRIO_MSB(0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid0), .req_ready(req_ready0), .req(req0),
    .gnt_valid(gnt_valid0), .gnt_ready(gnt_ready0), .gnt(gnt0), .busy(busy0)
`ifdef REQ_LATCH_ARBITER_GNT_IDX_EN
    , .gnt_idx(gnt_idx0)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid1 = 1'b0; req1 = 8'h00; gnt_ready1 = 1'b0;
    req_valid0 = 1'b0; req0 = 8'h00; gnt_ready0 = 1'b0;
    #1;
    checks++;
    if ({req_ready1, gnt_valid1, busy1, gnt1} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_msb: rdy/vld/busy/gnt got %b/%b/%b/%h required 1/0/0/00",
               req_ready1, gnt_valid1, busy1, gnt1);
    end
    checks++;
    if ({req_ready0, gnt_valid0, busy0, gnt0} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_lsb: rdy/vld/busy/gnt got %b/%b/%b/%h required 1/0/0/00",
               req_ready0, gnt_valid0, busy0, gnt0);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_msb_sequence();
    logic [7:0] exp_gnt [3] = '{8'h80, 8'h20, 8'h04};
`ifdef REQ_LATCH_ARBITER_GNT_IDX_EN
    logic [2:0] exp_idx [3] = '{3'd7, 3'd5, 3'd2};
`endif
    gnt_ready1 = 1'b1;
    req1 = 8'b1010_0100; req_valid1 = 1'b1;
    tick();
    req_valid1 = 1'b0; req1 = 8'h00;
    checks++;
    if ({busy1, req_ready1, gnt_valid1} !== 3'b100) begin
      errors++;
      $display("FAIL seq_capture: busy/rdy/vld got %b%b%b required 100", busy1, req_ready1, gnt_valid1);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({gnt_valid1, gnt1} !== {1'b1, exp_gnt[k]}) begin
        errors++;
        $display("FAIL seq_grant%0d: vld/gnt got %b/%h required 1/%h", k, gnt_valid1, gnt1, exp_gnt[k]);
      end
`ifdef REQ_LATCH_ARBITER_GNT_IDX_EN
      checks++;
      if (gnt_idx1 !== exp_idx[k]) begin
        errors++;
        $display("FAIL seq_idx%0d: got %0d required %0d", k, gnt_idx1, exp_idx[k]);
      end
`endif
      tick();
      checks++;
      if ({gnt_valid1, gnt1} !== 9'h000) begin
        errors++;
        $display("FAIL seq_release%0d: vld/gnt got %b/%h required 0/00", k, gnt_valid1, gnt1);
      end
    end
    checks++;
    if ({req_ready1, busy1} !== 2'b10) begin
      errors++;
      $display("FAIL seq_idle: rdy/busy got %b%b required 10", req_ready1, busy1);
    end
  endtask

  task automatic test_stall();
    gnt_ready1 = 1'b0;
    req1 = 8'b0001_0010; req_valid1 = 1'b1;
    tick();
    req_valid1 = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      req_valid1 = 1'b1; req1 = 8'hFF;
      checks++;
      if ({gnt_valid1, gnt1, req_ready1} !== {1'b1, 8'h10, 1'b0}) begin
        errors++;
        $display("FAIL stall_hold%0d: vld/gnt/rdy got %b/%h/%b required 1/10/0", k, gnt_valid1, gnt1, req_ready1);
      end
      tick();
    end
    req_valid1 = 1'b0; req1 = 8'h00;
    checks++;
    if ({gnt_valid1, gnt1} !== {1'b1, 8'h10}) begin
      errors++;
      $display("FAIL stall_last: vld/gnt got %b/%h required 1/10", gnt_valid1, gnt1);
    end
    gnt_ready1 = 1'b1;
    tick();
    tick();
    checks++;
    if ({gnt_valid1, gnt1} !== {1'b1, 8'h02}) begin
      errors++;
      $display("FAIL stall_next: vld/gnt got %b/%h required 1/02", gnt_valid1, gnt1);
    end
    tick();
    tick();
    checks++;
    if ({req_ready1, busy1, gnt_valid1} !== 3'b100) begin
      errors++;
      $display("FAIL stall_drained: rdy/busy/vld got %b%b%b required 100", req_ready1, busy1, gnt_valid1);
    end
  endtask

  task automatic test_zero_req();
    req1 = 8'h00; req_valid1 = 1'b1;
    tick();
    req_valid1 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({req_ready1, busy1, gnt_valid1, gnt1} !== {3'b100, 8'h00}) begin
        errors++;
        $display("FAIL zero_req%0d: rdy/busy/vld/gnt got %b%b%b/%h required 100/00",
                 k, req_ready1, busy1, gnt_valid1, gnt1);
      end
      tick();
    end
  endtask

  task automatic test_lsb_full_drain();
    logic [7:0] exp;
    gnt_ready0 = 1'b1;
    req0 = 8'hFF; req_valid0 = 1'b1;
    tick();
    req_valid0 = 1'b0; req0 = 8'h00;
    for (int k = 0; k < 8; k++) begin
      exp = 8'h01 << k;
      tick();
      checks++;
      if ($isunknown(gnt0) || gnt0 !== exp || gnt_valid0 !== 1'b1) begin
        errors++;
        $display("FAIL lsb_grant%0d: vld/gnt got %b/%h required 1/%h", k, gnt_valid0, gnt0, exp);
      end
      tick();
    end
    checks++;
    if ({req_ready0, busy0, gnt_valid0} !== 3'b100) begin
      errors++;
      $display("FAIL lsb_drained: rdy/busy/vld got %b%b%b required 100", req_ready0, busy0, gnt_valid0);
    end
    tick();
    checks++;
    if (gnt_valid0 !== 1'b0) begin
      errors++;
      $display("FAIL lsb_no_regrant: vld got %b required 0", gnt_valid0);
    end
  endtask

  task automatic test_reset_mid_grant();
    gnt_ready1 = 1'b0;
    req1 = 8'b0111_0000; req_valid1 = 1'b1;
    tick();
    req_valid1 = 1'b0; req1 = 8'h00;
    tick();
    checks++;
    if ({gnt_valid1, gnt1} !== {1'b1, 8'h40}) begin
      errors++;
      $display("FAIL rst_pre: vld/gnt got %b/%h required 1/40", gnt_valid1, gnt1);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready1, busy1, gnt_valid1, gnt1} !== {3'b100, 8'h00}) begin
      errors++;
      $display("FAIL rst_async: rdy/busy/vld/gnt got %b%b%b/%h required 100/00",
               req_ready1, busy1, gnt_valid1, gnt1);
    end
    #2 rst_n = 1'b1;
    gnt_ready1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if ({busy1, gnt_valid1, gnt1} !== 10'h000) begin
        errors++;
        $display("FAIL rst_quiet%0d: busy/vld/gnt got %b%b/%h required 00/00", k, busy1, gnt_valid1, gnt1);
      end
    end
    req1 = 8'h01; req_valid1 = 1'b1;
    tick();
    req_valid1 = 1'b0; req1 = 8'h00;
    tick();
    checks++;
    if ({gnt_valid1, gnt1} !== {1'b1, 8'h01}) begin
      errors++;
      $display("FAIL rst_new_req: vld/gnt got %b/%h required 1/01", gnt_valid1, gnt1);
    end
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_msb_sequence();
    test_stall();
    test_zero_req();
    test_lsb_full_drain();
    test_reset_mid_grant();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
